// File: rtl/pmips_fetch_stage.sv
// Instruction-fetch stage for the 16-bit PMIPS core.
// Owns the PC and drives the instruction memory address. An 8-entry table of
// 2-bit saturating counters predicts conditional branches. The stage also holds
// the IF/ID pipeline register and redirects fetch on an execute-stage mispredict.
module pmips_fetch_stage #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] imemaddr,
    input  logic [15:0] imemrdata,
    input  logic        stall,
    input  logic        res_valid,
    input  logic [15:0] res_pc,
    input  logic        res_taken,
    input  logic [15:0] res_target,
    input  logic        res_pred,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic        ifid_valid,
    output logic        ifid_pred,
    output logic        flush,
    output logic [1:0]  pred_state
);

    logic [15:0] pc_q, pc_d;
    logic [1:0]  ctr_q [8];

    logic        is_branch;
    logic        predict;
    logic [2:0]  idx;
    logic [2:0]  res_idx;
    logic [15:0] pc_plus2;
    logic [15:0] br_offset;
    logic [15:0] br_target;
    logic [1:0]  ctr_upd;

    // Branch decode, prediction lookup and redirect detection.
    always_comb begin
        is_branch  = (imemrdata[15:13] == 3'b101) || (imemrdata[15:13] == 3'b110);
        idx        = pc_q[3:1];
        res_idx    = res_pc[3:1];
        pc_plus2   = pc_q + 16'd2;
        // Sign-extended 7-bit word offset, shifted to a byte offset.
        br_offset  = {{8{imemrdata[6]}}, imemrdata[6:0], 1'b0};
        br_target  = pc_plus2 + br_offset;
        // The lookup reads the registered value, which is the pre-update counter.
        pred_state = ctr_q[idx];
        predict    = is_branch && ctr_q[idx][1];
        flush      = res_valid && (res_pred != res_taken);
        imemaddr   = pc_q;
    end

    // Next-PC selection: a flush overrides a stall, and a stall overrides a prediction.
    always_comb begin
        pc_d = pc_plus2;
        if (flush) begin
            pc_d = res_taken ? res_target : (res_pc + 16'd2);
        end else if (stall) begin
            pc_d = pc_q;
        end else if (predict) begin
            pc_d = br_target;
        end
    end

    // Saturating update of the counter for the resolving branch.
    always_comb begin
        ctr_upd = ctr_q[res_idx];
        if (res_taken) begin
            if (ctr_q[res_idx] != 2'b11) ctr_upd = ctr_q[res_idx] + 2'b01;
        end else begin
            if (ctr_q[res_idx] != 2'b00) ctr_upd = ctr_q[res_idx] - 2'b01;
        end
    end

    // PC register.
    always_ff @(posedge clock) begin
        if (reset) pc_q <= PC_RESET;
        else       pc_q <= pc_d;
    end

    // Predictor table; trains on every resolution regardless of stall or flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) ctr_q[i] <= CTR_INIT;
        end else if (res_valid) begin
            ctr_q[res_idx] <= ctr_upd;
        end
    end

    // IF/ID register: a flush inserts a bubble, a stall holds the current contents.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            ifid_instr <= 16'h0000;
            ifid_pc    <= 16'h0000;
            ifid_valid <= 1'b0;
            ifid_pred  <= 1'b0;
        end else if (!stall) begin
            ifid_instr <= imemrdata;
            ifid_pc    <= pc_q;
            ifid_valid <= 1'b1;
            ifid_pred  <= predict;
        end
    end

endmodule

// File: doc/pmips_fetch_stage.md
# pmips_fetch_stage

Instruction-fetch stage for the 16-bit pipelined PMIPS core. It owns the PC, drives the combinational instruction memory, and predicts conditional branches with an 8-entry table of 2-bit saturating counters. It captures the IF/ID pipeline register and redirects fetch when the execute stage reports a misprediction. It sits directly upstream of the decode stage and feeds it instruction, PC and prediction bit.

## Interface
- PC_RESET, 16'h0000, PC value loaded on reset
- CTR_INIT, 2'b01, reset value of every predictor counter (weakly not-taken)

- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- imemaddr  out  16  instruction memory address; equals PC register
- imemrdata  in  16  instruction memory read data; combinational from imemaddr
- stall  in  1  hazard stall from decode; holds PC and IF/ID
- res_valid  in  1  execute stage is resolving a conditional branch this cycle
- res_pc  in  16  PC of the resolving branch
- res_taken  in  1  actual branch outcome
- res_target  in  16  computed taken target of the resolving branch
- res_pred  in  1  prediction bit that travelled with that branch
- ifid_instr  out  16  IF/ID instruction register
- ifid_pc  out  16  IF/ID PC register
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_pred  out  1  predicted-taken bit for ifid_instr
- flush  out  1  combinational; high when res_valid and res_pred != res_taken
- pred_state  out  2  counter value for the current PC index (debug)

## Operation
- Branch decode on imemrdata: opcode [15:13] == 3'b101 (beq) or 3'b110 (bne); imm = [6:0], signed.
- Fetch target: pc_plus2 = PC + 2; br_target = pc_plus2 + (sext(imm) << 1); 16-bit, wraps modulo 2^16.
- Table index = PC[3:1]; predict taken when the instruction is a branch and counter[1] == 1.
- next_pc priority: reset -> PC_RESET; flush -> (res_taken ? res_target : res_pc + 2); stall -> PC; predicted taken -> br_target; else pc_plus2.
- IF/ID update priority: reset or flush -> instr 16'h0000, pc 0, valid 0, pred 0; stall -> hold; else load {imemrdata, PC, 1, predict}.
- Counter update when res_valid, at index res_pc[3:1]: taken -> saturating increment (max 2'b11), not taken -> saturating decrement (min 2'b00). Update happens regardless of stall or flush.
- Counter read and write to the same index in one cycle: lookup uses the pre-update value.
- Non-branch instructions never consult or modify the table.

## Timing
- Reset values: PC = PC_RESET, imemaddr = PC_RESET, IF/ID all zero, ifid_valid = 0, all counters = CTR_INIT, flush = 0 (res_valid low), pred_state = CTR_INIT.
- Fetch latency: instruction at PC appears on ifid_instr one edge after PC is presented.
- Predicted-taken branch: zero-bubble; target is fetched the cycle after the branch is fetched.
- Mispredict: flush high in the resolving cycle; next edge loads corrected PC and a bubble into IF/ID; corrected instruction reaches IF/ID one cycle later (penalty set by decode/execute depth).
- Flush overrides stall in the same cycle.
- Reset mid-stall or mid-flush: reset wins; all state returns to reset values on that edge.

## Test plan
- Reset for 1 cycle, then run sequential non-branch code -> imemaddr 0,2,4,6 on successive edges; ifid_pc lags imemaddr by one cycle; ifid_valid 0 until first edge after reset release.
- Assert stall for 2 cycles at PC=6 -> imemaddr stays 6, ifid_instr/ifid_pc unchanged; resumes 8 after stall drops.
- beq at PC=4 with imm=-2, counter index 2 = 01 -> predicted not-taken, next PC 6, ifid_pred 0; drive res_valid, res_pc=4, res_taken=1, res_target=2, res_pred=0 -> flush=1, next PC 2, ifid_valid 0, counter[2] = 10.
- After training counter[2] to 11, refetch beq at PC=4 -> next PC 2, ifid_pred 1; resolve taken twice more -> counter stays 11; resolve not-taken with res_pred=1 -> flush, next PC 6, counter 10.
- Same-cycle stall=1 and flush=1 -> PC loads corrected address, IF/ID cleared (flush wins).
- Branch at PC=16'hFFFE, not taken -> next PC 16'h0000 (wrap); update and lookup on same index same cycle -> prediction uses old counter value.
